// File: rtl/rv32i_lsu_if.sv
// Data-memory port of the RV32I load/store unit: req/gnt request phase plus
// an rvalid response phase for loads.
interface rv32i_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one access at a time over a req/gnt/rvalid port,
// stalling the pipeline until the access completes, faults or times out.
module rv32i_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ex_valid,
  input  logic         ex_mem_read,
  input  logic         ex_mem_write,
  input  logic [2:0]   ex_funct3,
  input  logic [31:0]  ex_addr,
  input  logic [31:0]  ex_wdata,
  input  logic         flush,
  output logic         lsu_stall,
  output logic         lsu_done,
  output logic [31:0]  lsu_rdata,
  output logic         misalign_fault,
  output logic         bus_err,
  output logic [31:0]  fault_addr,
  rv32i_lsu_if.master  dmem
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  // Zero-extension is meaningless for stores, so funct3[2] is illegal there.
  function automatic logic op_illegal(input logic [2:0] f3, input logic we);
    return (f3[1:0] == 2'b11) || (f3[2] && f3[1]) || (we && f3[2]);
  endfunction

  function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] lane;
    lane = rd >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{lane[7]}}, lane[7:0]};
      3'b100:  return {24'h000000, lane[7:0]};
      3'b001:  return {{16{lane[15]}}, lane[15:0]};
      3'b101:  return {16'h0000, lane[15:0]};
      3'b010:  return lane;
      default: return 32'h0000_0000;
    endcase
  endfunction

  state_t      state_r, next_s;
  logic [31:0] addr_r;
  logic [2:0]  funct3_r;
  logic        we_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [CNT_W-1:0] cnt_r;
  logic        done_r, misalign_r, bus_err_r;
  logic [31:0] rdata_r, fault_addr_r;

  logic accept_s, stall_s, timeout_s, load_done_s, store_done_s;
  logic op_bad_s, to_hit_s;

  assign op_bad_s = op_illegal(ex_funct3, ex_mem_write) ||
                    op_misaligned(ex_funct3, ex_addr[1:0]);
  assign to_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_r >= CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and strobe decode.
  always_comb begin
    next_s       = state_r;
    stall_s      = 1'b0;
    accept_s     = 1'b0;
    timeout_s    = 1'b0;
    load_done_s  = 1'b0;
    store_done_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (ex_valid && (ex_mem_read || ex_mem_write) && !flush) begin
          accept_s = 1'b1;
          stall_s  = 1'b1;
          next_s   = op_bad_s ? S_FAULT : S_REQ;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_REQ: begin
        stall_s = !flush;
        if (flush) begin
          next_s = S_IDLE;
        end else if (dmem.dmem_gnt) begin
          if (we_r) begin
            next_s       = S_DONE;
            store_done_s = 1'b1;
          end else begin
            next_s = S_WAIT;
          end
        end else if (to_hit_s) begin
          next_s    = S_DONE;
          timeout_s = 1'b1;
        end else begin
          next_s = S_REQ;
        end
      end
      S_WAIT: begin
        stall_s = !flush;
        if (flush) begin
          next_s = S_DRAIN;
        end else if (dmem.dmem_rvalid) begin
          next_s      = S_DONE;
          load_done_s = 1'b1;
        end else if (to_hit_s) begin
          next_s    = S_DONE;
          timeout_s = 1'b1;
        end else begin
          next_s = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (dmem.dmem_rvalid) begin
          next_s = S_IDLE;
        end else begin
          next_s = S_DRAIN;
        end
      end
      S_DONE:  next_s = S_IDLE;
      S_FAULT: next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Access capture at accept; request fields stay stable through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r   <= 32'h0000_0000;
      funct3_r <= 3'b000;
      we_r     <= 1'b0;
      be_r     <= 4'b0000;
      wdata_r  <= 32'h0000_0000;
    end else if (accept_s) begin
      addr_r   <= ex_addr;
      funct3_r <= ex_funct3;
      we_r     <= ex_mem_write;
      be_r     <= byte_en(ex_funct3, ex_addr[1:0]);
      wdata_r  <= store_data(ex_funct3, ex_wdata);
    end else begin
      addr_r   <= addr_r;
      funct3_r <= funct3_r;
      we_r     <= we_r;
      be_r     <= be_r;
      wdata_r  <= wdata_r;
    end
  end

  // Cycles spent in REQ+WAIT for the current access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= '0;
    end else if (state_r == S_REQ || state_r == S_WAIT) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Completion outputs: rdata and fault flags are only non-zero in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r       <= 1'b0;
      misalign_r   <= 1'b0;
      bus_err_r    <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      fault_addr_r <= 32'h0000_0000;
    end else begin
      done_r     <= (accept_s && op_bad_s) || timeout_s || load_done_s || store_done_s;
      misalign_r <= accept_s && op_bad_s;
      bus_err_r  <= timeout_s;
      rdata_r    <= load_done_s ? load_ext(funct3_r, addr_r[1:0], dmem.dmem_rdata)
                                : 32'h0000_0000;
      if (accept_s && op_bad_s) begin
        fault_addr_r <= ex_addr;
      end else if (timeout_s) begin
        fault_addr_r <= addr_r;
      end else begin
        fault_addr_r <= fault_addr_r;
      end
    end
  end

  assign lsu_stall      = stall_s;
  assign lsu_done       = done_r;
  assign lsu_rdata      = rdata_r;
  assign misalign_fault = misalign_r;
  assign bus_err        = bus_err_r;
  assign fault_addr     = fault_addr_r;

  assign dmem.dmem_req   = (state_r == S_REQ);
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = {addr_r[31:2], 2'b00};
  assign dmem.dmem_be    = be_r;
  assign dmem.dmem_wdata = wdata_r;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu: directed accesses push expected bus requests
// and completions; monitors compare whenever the DUTs present them.
module tb_rv32i_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        berr;
    logic [31:0] faddr;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, to_valid = 1'b0;
  logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_addr = 32'h0, ex_wdata = 32'h0;
  logic        flush = 1'b0;

  logic        lsu_stall, lsu_done, misalign_fault, bus_err;
  logic [31:0] lsu_rdata, fault_addr;
  logic        to_stall, to_done, to_mis, to_berr;
  logic [31:0] to_rdata, to_faddr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t exp_q[$];
  exp_t to_q[$];
  req_t req_q[$];

  rv32i_lsu_if bus();
  rv32i_lsu_if bus_to();

  rv32i_lsu dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .flush(flush), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
    .lsu_rdata(lsu_rdata), .misalign_fault(misalign_fault), .bus_err(bus_err),
    .fault_addr(fault_addr), .dmem(bus)
  );

  rv32i_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .ex_valid(to_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .flush(1'b0), .lsu_stall(to_stall), .lsu_done(to_done),
    .lsu_rdata(to_rdata), .misalign_fault(to_mis), .bus_err(to_berr),
    .fault_addr(to_faddr), .dmem(bus_to)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Main-DUT monitor: bus requests and completions against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (lsu_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_rdata", lsu_rdata, e.rdata);
          chk("done_misalign", {31'd0, misalign_fault}, {31'd0, e.mis});
          chk("done_bus_err", {31'd0, bus_err}, {31'd0, e.berr});
          chk("done_stall_low", {31'd0, lsu_stall}, 32'd0);
          if (e.mis || e.berr) chk("fault_addr", fault_addr, e.faddr);
        end
      end
      if (bus.dmem_req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("req_addr", bus.dmem_addr, req_q[0].addr);
          chk("req_be", {28'd0, bus.dmem_be}, {28'd0, req_q[0].be});
          chk("req_we", {31'd0, bus.dmem_we}, {31'd0, req_q[0].we});
          chk("req_wdata", bus.dmem_wdata, req_q[0].wdata);
          if (bus.dmem_gnt) void'(req_q.pop_front());
        end
      end
    end
  end

  // Timeout-DUT monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && to_done) begin
      if (to_q.size() == 0) begin
        chk("to_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = to_q.pop_front();
        chk("to_done_cycle", cyc, e.cyc);
        chk("to_bus_err", {31'd0, to_berr}, {31'd0, e.berr});
        chk("to_misalign", {31'd0, to_mis}, {31'd0, e.mis});
        chk("to_rdata", to_rdata, e.rdata);
        chk("to_fault_addr", to_faddr, e.faddr);
      end
    end
  end

  // One access on the main DUT with a scripted memory response.
  task automatic do_op(input logic is_rd, input logic is_wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int gnt_dly, input int rv_dly, input logic [31:0] mem_word,
                       input logic is_fault, input logic [31:0] exp_rdata,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int n;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_read = is_rd; ex_mem_write = is_wr;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
    n = cyc;
    #1 chk("stall_accept", {31'd0, lsu_stall}, 32'd1);
    if (is_fault) exp_q.push_back('{32'h0, 1'b1, 1'b0, a, n + 1});
    else req_q.push_back('{{a[31:2], 2'b00}, exp_be, is_wr, exp_wd});
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    if (is_fault) begin
      chk("fault_no_req", {31'd0, bus.dmem_req}, 32'd0);
      @(posedge clk); #1;
      chk("fault_no_req2", {31'd0, bus.dmem_req}, 32'd0);
    end else begin
      for (int k = 0; k < gnt_dly; k++) begin
        chk("stall_req", {31'd0, lsu_stall}, 32'd1);
        @(posedge clk); #1;
      end
      bus.dmem_gnt = 1'b1;
      #1 chk("stall_gnt", {31'd0, lsu_stall}, 32'd1);
      if (is_wr) exp_q.push_back('{32'h0, 1'b0, 1'b0, 32'h0, cyc + 1});
      @(posedge clk); #1;
      bus.dmem_gnt = 1'b0;
      if (!is_wr) begin
        for (int k = 0; k < rv_dly - 1; k++) begin
          chk("stall_wait", {31'd0, lsu_stall}, 32'd1);
          @(posedge clk); #1;
        end
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = mem_word;
        exp_q.push_back('{exp_rdata, 1'b0, 1'b0, 32'h0, cyc + 1});
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
    bus_to.dmem_gnt = 1'b0; bus_to.dmem_rvalid = 1'b0; bus_to.dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_done", {31'd0, lsu_done}, 32'd0);
    chk("rst_stall", {31'd0, lsu_stall}, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_flags", {30'd0, misalign_fault, bus_err}, 32'd0);
    chk("rst_faddr", fault_addr, 32'd0);
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_bus", {bus.dmem_addr[27:0], bus.dmem_be}, 32'd0);
    chk("rst_wdata", bus.dmem_wdata, 32'd0);

    // Stores: word, byte lane 3, half lane 2, read+write treated as store.
    do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF);
    do_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 0, 32'h0, 1'b0, 32'h0, 4'b1000, 32'hA5A5A5A5);
    do_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 32'h0, 1'b0, 32'h0, 4'b1100, 32'hABCDABCD);
    do_op(1'b1, 1'b1, 3'b000, 32'h101, 32'h0000005A, 0, 0, 32'h0, 1'b0, 32'h0, 4'b0010, 32'h5A5A5A5A);
    // Loads with extension.
    do_op(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 0, 1, 32'h80F17F00, 1'b0, 32'hFFFFFFF1, 4'b0100, 32'h0);
    do_op(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 0, 1, 32'h80F17F00, 1'b0, 32'h000000F1, 4'b0100, 32'h0);
    do_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h80F17F00, 1'b0, 32'hFFFF80F1, 4'b1100, 32'h0);
    do_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 1, 32'h80F17F00, 1'b0, 32'h000080F1, 4'b1100, 32'h0);
    do_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0, 1, 32'h89ABCDEF, 1'b0, 32'h89ABCDEF, 4'b1111, 32'h0);
    do_op(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 0, 1, 32'h1234567F, 1'b0, 32'h0000007F, 4'b0001, 32'h0);
    // Misaligned and illegal accesses.
    do_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_op(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_op(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_op(1'b1, 1'b0, 3'b110, 32'h104, 32'h0, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    // Slow memory: gnt after 3 cycles, rvalid 2 cycles later.
    do_op(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 3, 2, 32'h0BADCAFE, 1'b0, 32'h0BADCAFE, 4'b1111, 32'h0);

    // Flush in IDLE blocks the accept.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h140; flush = 1'b1;
    #1 chk("flush_idle_stall", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; flush = 1'b0;
    chk("flush_idle_no_req", {31'd0, bus.dmem_req}, 32'd0);

    // Flush during REQ: request drops next cycle, no completion.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h160; ex_wdata = 32'h0;
    req_q.push_back('{32'h160, 4'b1111, 1'b0, 32'h0});
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; flush = 1'b1;
    #1 chk("flush_req_stall", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_req_dropped", {31'd0, bus.dmem_req}, 32'd0);
    req_q.delete();

    // Flush during WAIT: drain the late rvalid, no completion.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h180;
    req_q.push_back('{32'h180, 4'b1111, 1'b0, 32'h0});
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0; flush = 1'b1;
    #1 chk("flush_wait_stall", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("drain_stall", {31'd0, lsu_stall}, 32'd0);
    chk("drain_no_req", {31'd0, bus.dmem_req}, 32'd0);
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
    do_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 0, 1, 32'h12345678, 1'b0, 32'h12345678, 4'b1111, 32'h0);

    // Timeout instance: no gnt ever, bus_err at N+5, then a stray rvalid.
    @(posedge clk); #1;
    to_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h300;
    to_q.push_back('{32'h0, 1'b0, 1'b1, 32'h300, cyc + 5});
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      to_valid = 1'b0; ex_mem_read = 1'b0;
      chk("to_req_held", {31'd0, bus_to.dmem_req}, 32'd1);
    end
    @(posedge clk); #1;
    chk("to_req_dropped", {31'd0, bus_to.dmem_req}, 32'd0);
    chk("to_stall_done", {31'd0, to_stall}, 32'd0);
    @(posedge clk); #1;
    bus_to.dmem_rvalid = 1'b1; bus_to.dmem_rdata = 32'h55555555;
    @(posedge clk); #1;
    bus_to.dmem_rvalid = 1'b0;
    repeat (3) @(posedge clk);

    // Async reset in REQ drops the request immediately.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h400;
    req_q.push_back('{32'h400, 4'b1111, 1'b0, 32'h0});
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    chk("pre_rst_req", {31'd0, bus.dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1 chk("async_rst_req", {31'd0, bus.dmem_req}, 32'd0);
    req_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("to_q_empty", to_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
